// File: rtl/nibble_acc_pkg.sv
// Shared widths and FSM state encoding for the nibble accumulator.
// The burst total is {carry count, running nibble}, so TOTAL_W = LEN_W + DATA_W.
package nibble_acc_pkg;

  localparam int DATA_W  = 4;
  localparam int LEN_W   = 4;
  localparam int TOTAL_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_accumulator_adder.sv
// 4-bit unsigned adder with carry-out. Purely combinational (0 cycles).
// No handshake of its own, so it never applies backpressure.
module nibble_accumulator_adder
  import nibble_acc_pkg::*;
(
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, dataA} + {1'b0, dataB};

endmodule

// File: rtl/nibble_accumulator.sv
// Sums a burst of len nibbles. The result appears 1 cycle after the last operand.
// The result is held in DONE until out_ready. in_ready is high only in ACCUM.
module nibble_accumulator
  import nibble_acc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  dataIn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] total,
  output logic [LEN_W-1:0]   carryCount,
  output logic               busy
);

  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  acc_q;
  logic [LEN_W-1:0]   carry_cnt_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [DATA_W-1:0]  add_sum;
  logic               add_carry;
  logic               xfer;

  nibble_accumulator_adder u_adder (
    .dataA (acc_q),
    .dataB (dataIn),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign xfer = (state_q == ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (remaining_q == LEN_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      carry_cnt_q <= '0;
      remaining_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        acc_q       <= '0;
        carry_cnt_q <= '0;
        remaining_q <= len;
      end
    end else if (xfer) begin
      acc_q       <= add_sum;
      carry_cnt_q <= carry_cnt_q + {{(LEN_W-1){1'b0}}, add_carry};
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  // Each carry-out is worth 16, so the exact total is a concatenation.
  assign total      = {carry_cnt_q, acc_q};
  assign carryCount = carry_cnt_q;
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_accumulator.sv
// Directed bench: stimulus pushes hand-computed {total, carryCount} results;
// a forked monitor pops and compares on every out_valid && out_ready handshake.
module tb_nibble_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dataIn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] total;
  logic [3:0] carryCount;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dataIn     (dataIn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .total      (total),
    .carryCount (carryCount),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    dataIn   = d;
    tick();
    in_valid = 1'b0;
  endtask

  // {in_ready, out_valid, busy}
  task automatic check_ctl(input string name, input logic [2:0] req);
    check(name, {9'd0, in_ready, out_valid, busy}, {9'd0, req});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; dataIn = '0; out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", {total, carryCount}, 12'hfff);
            if ({total, carryCount} == 12'hfff) begin
              failures++;
              $display("FAIL unexpected_result actual=result required=none");
            end
          end else begin
            check("result", {total, carryCount}, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset with everything else asserted: reset wins.
    start = 1'b1; in_valid = 1'b1; dataIn = 4'd9; len = 4'd3;
    tick(); tick();
    check_ctl("reset_ctl", 3'b000);
    check("reset_data", {total, carryCount}, 12'h000);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // 9+8+7 = 24 = 0x18, one carry.
    exp_q.push_back({8'h18, 4'd1});
    do_start(4'd3);
    check_ctl("accum_ctl", 3'b101);
    in_valid = 1'b1;
    dataIn = 4'd9; tick();
    dataIn = 4'd8; tick();
    dataIn = 4'd7; tick();
    in_valid = 1'b0;
    check_ctl("len3_done_latency", 3'b011);
    tick();
    check_ctl("len3_back_idle", 3'b000);

    // Fifteen 15s = 225 = 0xE1, fourteen carries.
    exp_q.push_back({8'he1, 4'd14});
    do_start(4'd15);
    in_valid = 1'b1; dataIn = 4'd15;
    for (int i = 0; i < 14; i++) tick();
    check_ctl("len15_still_accum", 3'b101);
    tick();
    in_valid = 1'b0;
    check_ctl("len15_done", 3'b011);
    tick();

    // len=0 goes straight to DONE with zero result.
    exp_q.push_back({8'h00, 4'd0});
    do_start(4'd0);
    check_ctl("len0_done", 3'b011);
    tick();
    check_ctl("len0_idle", 3'b000);

    // Out-of-burst pulses are ignored, then 5 + gap + 6 = 11.
    in_valid = 1'b1; dataIn = 4'd15;
    tick(); tick();
    in_valid = 1'b0;
    check_ctl("idle_ignores_in_valid", 3'b000);
    exp_q.push_back({8'd11, 4'd0});
    do_start(4'd2);
    send(4'd5);
    tick(); tick();
    check_ctl("gap_holds_accum", 3'b101);
    send(4'd6);
    check_ctl("gap_done", 3'b011);
    in_valid = 1'b1; dataIn = 4'd15;
    tick();
    in_valid = 1'b0;
    check_ctl("done_ignores_in_valid", 3'b000);

    // Backpressure: 3+4 = 7 held while start toggles.
    out_ready = 1'b0;
    exp_q.push_back({8'd7, 4'd0});
    do_start(4'd2);
    send(4'd3);
    send(4'd4);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 4'd5;
      check_ctl("held_ctl", 3'b011);
      check("held_data", {total, carryCount}, {8'd7, 4'd0});
      tick();
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check_ctl("release_to_idle", 3'b000);
    tick();
    check_ctl("start_in_done_ignored", 3'b000);

    // Reset mid-burst discards the partial sum.
    do_start(4'd4);
    send(4'd9);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; dataIn = 4'd9;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_ctl("midburst_reset_ctl", 3'b000);
    check("midburst_reset_data", {total, carryCount}, 12'h000);
    tick();
    exp_q.push_back({8'd3, 4'd0});
    do_start(4'd1);
    send(4'd3);
    check_ctl("after_reset_done", 3'b011);
    tick(); tick();

    check("scoreboard_drained", 12'(exp_q.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_accumulator.md
NIBBLE_ACCUMULATOR -- requirements
Module: nibble_accumulator

Interface
REQ-001 Parameters: none; all widths are fixed by package constants (DATA_W=4, LEN_W=4, TOTAL_W=8).
REQ-002 One clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  begin a burst; sampled only in IDLE.
REQ-006 len  input  4  number of operands in the burst (0..15), sampled with start.
REQ-007 in_valid  input  1  dataIn is valid this cycle.
REQ-008 in_ready  output  1  block accepts dataIn this cycle.
REQ-009 dataIn  input  4  unsigned operand nibble.
REQ-010 out_valid  output  1  total/carryCount are valid and held.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 total  output  8  exact unsigned sum of the burst, equal to 16*carryCount + running 4-bit sum.
REQ-013 carryCount  output  4  number of adder carry-outs seen in the burst.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 IDLE, start=1, len!=0: clear acc and carryCount, set the remaining-count register to len, and go to ACCUM next cycle.
REQ-017 IDLE, start=1, len=0: clear acc and carryCount, and go directly to DONE (out_valid next cycle, total=0).
REQ-018 IDLE, start=0: hold; in_ready=0, out_valid=0.
REQ-019 ACCUM: in_ready=1; a transfer occurs on in_valid&&in_ready.
- On each transfer: acc<=sum[3:0] of acc+dataIn; carryCount<=carryCount+carry; remaining<=remaining-1.
REQ-020 ACCUM: in_valid=0 SHALL leave all state unchanged; gaps of any length are allowed.
REQ-021 ACCUM: a transfer with remaining==1 SHALL move to DONE; out_valid asserts the cycle after the last transfer (latency 1).
REQ-022 DONE: out_valid=1 and in_ready=0; total and carryCount SHALL be registered and stable until the handshake.
REQ-023 DONE, out_ready=1: return to IDLE next cycle; out_valid deasserts in that cycle.
REQ-024 start SHALL be ignored outside IDLE, including when start coincides with out_ready in DONE.
REQ-025 carryCount SHALL NOT wrap, because at most 15 additions occur. total SHALL equal the exact sum; the maximum is 15*15=225.
REQ-026 In ACCUM, in_ready SHALL be a function of state only, with no combinational path from in_valid.

Reset
REQ-027 rst in any state SHALL force IDLE on the next edge.
REQ-028 On that edge acc, carryCount, remaining and total SHALL be cleared to 0, and in_ready, out_valid and busy SHALL be 0.
REQ-029 rst mid-burst SHALL discard the partial sum; no out_valid is produced for that burst.
REQ-030 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-031 Package nibble_acc_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the constants DATA_W, LEN_W and TOTAL_W.
REQ-032 The existing 4-bit adder module SHALL be instantiated as the only sub-module, wired as dataA=acc, dataB=dataIn; its sum and carry feed the registers.
REQ-033 No other arithmetic is permitted on the data path, apart from the remaining/carryCount counters.

Verification
REQ-034 start, len=3; operands 9, 8, 7 on consecutive cycles -> out_valid 1 cycle after the 3rd operand; total=0x18 (24), carryCount=1.
REQ-035 start, len=15; all operands 15 -> total=0xE1 (225), carryCount=14 (15*15=225=16*14+1); no overflow.
REQ-036 start, len=0 -> out_valid next cycle, total=0, carryCount=0, in_ready never asserted.
REQ-037 start, len=2; operands 5, then in_valid low for 2 cycles, then 6 -> total=11, carryCount=0.
- Out-of-burst in_valid pulses are ignored.
REQ-038 Burst done with out_ready held low for 5 cycles while start toggles -> total stable and state stays DONE; out_ready=1 -> IDLE next cycle.
REQ-039 rst after 1 accepted operand of a len=4 burst -> next cycle IDLE with all outputs 0; then start, len=1, operand 3 -> total=3.
